// File: rtl/sifive_tl_ul_pkg.sv
// sifive_tl_ul_pkg
//   Shared definitions for the TileLink-UL responder slice:
//   - A-channel and D-channel opcode constants
//   - d_resp_t, the D-channel response record held in the response FIFO
//   - is_aligned(), the natural-alignment rule for a request of a given size
//
// The source field in d_resp_t is sized to SRC_MAX_W, so one record type serves
// any responder whose SOURCE_W is at most SRC_MAX_W. The responder zero-extends
// a_source into it and drives d_source from the low bits.

package sifive_tl_ul_pkg;

  // A-channel opcodes understood by the responder
  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_GET         = 3'd4;

  // D-channel opcodes produced by the responder
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  // Widest requester ID a response record can carry
  localparam int SRC_MAX_W = 8;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           size;
    logic [SRC_MAX_W-1:0] source;
    logic                 denied;
    logic                 corrupt;
    logic [31:0]          data;
  } d_resp_t;

  // A request of 1<<size bytes must start on a multiple of 1<<size.
  // Sizes above a full word are never aligned, since they are not supported.
  function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] lsb);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = ~lsb[0];
      3'd2:    ok = (lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sifive_tl_resp_fifo.sv
// sifive_tl_resp_fifo
//   Strictly ordered FIFO of D-channel response records.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high; empties the FIFO and zeroes pointers
//   push       enqueue push_data this cycle (ignored while full)
//   push_data  response record to enqueue
//   pop        dequeue the head this cycle (ignored while empty)
//   head       oldest record; only meaningful while !empty
//   full       count == DEPTH
//   empty      count == 0
//   count      number of records held
//
// Pointers wrap with an explicit compare against DEPTH-1, so DEPTH does not
// have to be a power of two. A simultaneous push and pop leaves count unchanged.

module sifive_tl_resp_fifo
  import sifive_tl_ul_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  d_resp_t          push_data,
  input  logic             pop,
  output d_resp_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  d_resp_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; count only moves when exactly one side acts
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed between push and pop
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sifive_tl_ul_responder.sv
// sifive_tl_ul_responder
//   TileLink-UL slave-side responder backed by a small word-addressed store.
//   Each accepted A-channel request is decoded, executed against the store and
//   turned into a D-channel response in the same cycle; the response is queued
//   and leaves in acceptance order with source and size echoed.
//
// Ports
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   a_valid / a_ready             A-channel handshake; a_ready = room in the queue
//   a_opcode, a_size, a_source    request kind, log2 bytes, requester ID
//   a_address, a_mask, a_data     byte address, byte lanes, write data
//   d_valid / d_ready             D-channel handshake; d_valid = queue not empty
//   d_opcode, d_size, d_source    AccessAck / AccessAckData, echoed size and ID
//   d_denied, d_corrupt, d_data   rejection flag, corrupt (denied Get only), read data
//
// All d_* payload outputs read as zero while d_valid is low. a_ready depends only
// on queue occupancy, so there is no combinational path from d_ready to a_ready.

module sifive_tl_ul_responder
  import sifive_tl_ul_pkg::*;
#(
  parameter int SOURCE_W = 4,
  parameter int ADDR_W   = 12,
  parameter int WORDS    = 8,
  parameter int QDEPTH   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [2:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [31:0]         d_data
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [31:0]          store [WORDS];

  logic                 accept;
  logic [ADDR_W-3:0]    word_index;
  logic [IDX_W-1:0]     word_sel;
  logic                 op_get;
  logic                 op_put;
  logic                 size_ok;
  logic                 align_ok;
  logic                 range_ok;
  logic                 denied;
  d_resp_t              req_resp;

  d_resp_t              fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_pop;
  d_resp_t              resp_out;
  logic [SRC_MAX_W-1:0] wide_source_unused_hi;

  // Request decode and denial rules. The range compare is one bit wider than
  // the word index so that WORDS equal to the whole address space still works.
  assign word_index = a_address[ADDR_W-1:2];
  assign word_sel   = word_index[IDX_W-1:0];
  assign op_get     = (a_opcode == A_GET);
  assign op_put     = (a_opcode == A_PUT_FULL) | (a_opcode == A_PUT_PARTIAL);
  assign size_ok    = (a_size <= 3'd2);
  assign align_ok   = is_aligned(a_size, a_address[1:0]);
  assign range_ok   = ({1'b0, word_index} < (ADDR_W - 1)'(WORDS));
  assign denied     = ~(op_get | op_put) | ~size_ok | ~align_ok | ~range_ok;

  assign a_ready = (fifo_count < CNT_W'(QDEPTH));
  assign accept  = a_valid & a_ready;

  // Build the response for the request on the A channel. A Get returns the
  // full word whatever the mask says; anything that is not a Get, including
  // unsupported opcodes, is answered with a plain AccessAck.
  always_comb begin
    req_resp        = '0;
    req_resp.size   = a_size;
    req_resp.source = SRC_MAX_W'(a_source);
    req_resp.denied = denied;
    if (op_get) begin
      req_resp.opcode  = D_ACCESS_ACK_DATA;
      req_resp.corrupt = denied;
      if (!denied) req_resp.data = store[word_sel];
    end else begin
      req_resp.opcode = D_ACCESS_ACK;
    end
  end

  // Register store: cleared by reset, written lane by lane on accepted,
  // non-denied Puts. A Get in the following cycle sees the new contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int w = 0; w < WORDS; w++) store[w] <= '0;
    end else if (accept && op_put && !denied) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) store[word_sel][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  assign fifo_pop = d_valid & d_ready;

  sifive_tl_resp_fifo #(
    .DEPTH (QDEPTH),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (req_resp),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign d_valid = ~fifo_empty;

  // Queue storage is not reset, so the head is masked to zero when idle
  always_comb begin
    resp_out = '0;
    if (d_valid) resp_out = fifo_head;
  end

  // The record carries a source field wider than SOURCE_W; only the low bits
  // go out on d_source
  assign wide_source_unused_hi = resp_out.source;

  assign d_opcode  = resp_out.opcode;
  assign d_size    = resp_out.size;
  assign d_source  = wide_source_unused_hi[SOURCE_W-1:0];
  assign d_denied  = resp_out.denied;
  assign d_corrupt = resp_out.corrupt;
  assign d_data    = resp_out.data;

  // The FIFO's flags and its count must always agree
  full_matches_count: assert property (@(posedge clock) disable iff (reset)
    (fifo_full == (fifo_count == CNT_W'(QDEPTH))) && (fifo_empty == (fifo_count == '0)));

  // A response held under backpressure must not change
  payload_stable: assert property (@(posedge clock) disable iff (reset)
    (d_valid && !d_ready) |=> (d_valid && $stable(resp_out)));

endmodule

// File: tb/tb_sifive_tl_ul_responder.sv
// tb_sifive_tl_ul_responder
//   Self-checking bench for sifive_tl_ul_responder. A behavioural model (a
//   queue of expected responses plus an array of store words) is compared with
//   the DUT on every falling edge; directed scenarios pin known literal values,
//   then a randomized run exercises the rest.

module tb_sifive_tl_ul_responder;

  localparam int SOURCE_W = 4;
  localparam int ADDR_W   = 12;
  localparam int WORDS    = 8;
  localparam int QDEPTH   = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0]   a_address;
  logic [3:0]          a_mask;
  logic [31:0]         a_data;
  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [2:0]          d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                d_denied;
  logic                d_corrupt;
  logic [31:0]         d_data;

  sifive_tl_ul_responder #(
    .SOURCE_W (SOURCE_W),
    .ADDR_W   (ADDR_W),
    .WORDS    (WORDS),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_denied  (d_denied),
    .d_corrupt (d_corrupt),
    .d_data    (d_data)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic                corrupt;
    logic [31:0]         data;
  } resp_t;

  resp_t       exp_q [$];
  resp_t       seen  [$];
  logic [31:0] mstore [WORDS];
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic resp_t dut_resp();
    return {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data};
  endfunction

  // Behavioural model of one access: decide denial from the rules, form the
  // response, and apply any permitted write to the model store
  function automatic resp_t model_access(input logic [2:0] op, input logic [2:0] size,
                                         input logic [SOURCE_W-1:0] src, input logic [ADDR_W-1:0] addr,
                                         input logic [3:0] mask, input logic [31:0] data);
    resp_t r;
    int    a;
    int    idx;
    bit    is_get;
    bit    is_put;
    bit    bad;
    a      = int'(addr);
    idx    = a / 4;
    is_get = (op == 3'd4);
    is_put = (op == 3'd0) || (op == 3'd1);
    bad    = !(is_get || is_put) || (size > 3'd2) || (idx >= WORDS);
    if (size <= 3'd2 && (a % (1 << size)) != 0) bad = 1'b1;
    r         = '0;
    r.opcode  = is_get ? 3'd1 : 3'd0;
    r.size    = size;
    r.source  = src;
    r.denied  = bad;
    r.corrupt = is_get && bad;
    if (is_get && !bad) r.data = mstore[idx];
    if (is_put && !bad) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) mstore[idx][8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  // Model state advances on each rising edge from the inputs held across it
  bit    m_accept;
  bit    m_deq;
  resp_t m_resp;
  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < WORDS; i++) mstore[i] = '0;
    end else begin
      m_accept = a_valid && (exp_q.size() < QDEPTH);
      m_deq    = d_ready && (exp_q.size() > 0);
      m_resp   = '0;
      if (m_accept) m_resp = model_access(a_opcode, a_size, a_source, a_address, a_mask, a_data);
      if (m_deq) void'(exp_q.pop_front());
      if (m_accept) exp_q.push_back(m_resp);
    end
  end

  // Compare DUT with model every falling edge; log responses that will dequeue
  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("a_ready", a_ready, exp_q.size() < QDEPTH);
      checkOutput("d_valid", d_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) checkOutput("d_payload", dut_resp(), exp_q[0]);
      else                  checkOutput("idle_payload", dut_resp(), 64'd0);
      if (d_valid && d_ready) seen.push_back(dut_resp());
    end
  end

  // Drive one request and hold it until accepted (bounded); returns the number
  // of refused cycles and d_valid as seen in the accepting cycle
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] size, input logic [SOURCE_W-1:0] src,
                               input logic [ADDR_W-1:0] addr, input logic [3:0] mask, input logic [31:0] data,
                               output int waited, output logic dv_at_accept);
    logic rdy;
    bit   done;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    waited    = 0;
    done      = 1'b0;
    dv_at_accept = 1'b0;
    while (!done) begin
      @(negedge clock);
      rdy = a_ready;
      dv_at_accept = d_valid;
      @(posedge clock);
      #1;
      if (rdy) done = 1'b1;
      else begin
        waited++;
        if (waited > 50) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: got no a_ready in %0d cycles, expected acceptance", waited);
          done = 1'b1;
        end
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          w;
    logic        dv;
    int          idx;
    int          r;
    logic [1:0]  off;
    logic [2:0]  sz;

    reset = 1'b1; a_valid = 1'b0; a_opcode = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] reset state");
    @(negedge clock);
    checkOutput("reset_a_ready", a_ready, 1);
    checkOutput("reset_d_valid", d_valid, 0);
    @(posedge clock);
    #1;

    $display("[TB] put then get");
    seen.delete();
    applyStimulus(3'd0, 3'd2, 4'd3, 12'h008, 4'hF, 32'hDEADBEEF, w, dv);
    applyStimulus(3'd4, 3'd2, 4'd5, 12'h008, 4'h0, 32'h0, w, dv);
    drain();
    checkOutput("put_get_count", seen.size(), 2);
    if (seen.size() >= 2) begin
      checkOutput("put_ack", seen[0], {3'd0, 3'd2, 4'd3, 1'b0, 1'b0, 32'h0});
      checkOutput("get_data", seen[1], {3'd1, 3'd2, 4'd5, 1'b0, 1'b0, 32'hDEADBEEF});
    end

    $display("[TB] partial put");
    seen.delete();
    applyStimulus(3'd1, 3'd2, 4'd2, 12'h004, 4'h5, 32'h11223344, w, dv);
    applyStimulus(3'd4, 3'd2, 4'd6, 12'h004, 4'h0, 32'h0, w, dv);
    drain();
    checkOutput("partial_count", seen.size(), 2);
    if (seen.size() >= 2)
      checkOutput("partial_data", seen[1], {3'd1, 3'd2, 4'd6, 1'b0, 1'b0, 32'h00220044});

    $display("[TB] denied requests");
    seen.delete();
    applyStimulus(3'd4, 3'd2, 4'd1, 12'h020, 4'h0, 32'h0, w, dv);
    applyStimulus(3'd4, 3'd3, 4'd2, 12'h000, 4'h0, 32'h0, w, dv);
    applyStimulus(3'd4, 3'd2, 4'd3, 12'h002, 4'h0, 32'h0, w, dv);
    applyStimulus(3'd0, 3'd2, 4'd4, 12'h00D, 4'hF, 32'hCAFEF00D, w, dv);
    applyStimulus(3'd2, 3'd2, 4'd7, 12'h000, 4'hF, 32'h12345678, w, dv);
    applyStimulus(3'd4, 3'd2, 4'd8, 12'h00C, 4'h0, 32'h0, w, dv);
    drain();
    checkOutput("denied_count", seen.size(), 6);
    if (seen.size() >= 6) begin
      checkOutput("deny_range", seen[0], {3'd1, 3'd2, 4'd1, 1'b1, 1'b1, 32'h0});
      checkOutput("deny_size3", seen[1], {3'd1, 3'd3, 4'd2, 1'b1, 1'b1, 32'h0});
      checkOutput("deny_align", seen[2], {3'd1, 3'd2, 4'd3, 1'b1, 1'b1, 32'h0});
      checkOutput("deny_put", seen[3], {3'd0, 3'd2, 4'd4, 1'b1, 1'b0, 32'h0});
      checkOutput("deny_opcode", seen[4], {3'd0, 3'd2, 4'd7, 1'b1, 1'b0, 32'h0});
      checkOutput("deny_no_write", seen[5], {3'd1, 3'd2, 4'd8, 1'b0, 1'b0, 32'h0});
    end

    $display("[TB] backpressure");
    seen.delete();
    d_ready = 1'b0;
    a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd2; a_address = 12'h008; a_mask = '0; a_data = '0;
    a_source = 4'd1;
    @(negedge clock); checkOutput("bp_ready_first", a_ready, 1);
    @(posedge clock); #1; a_source = 4'd2;
    @(negedge clock); checkOutput("bp_ready_second", a_ready, 1);
    @(posedge clock); #1; a_source = 4'd3;
    @(negedge clock); checkOutput("bp_full", a_ready, 0);
    @(posedge clock); #1;
    @(negedge clock); checkOutput("bp_full_hold", a_ready, 0); checkOutput("bp_d_valid", d_valid, 1);
    @(posedge clock); #1; d_ready = 1'b1;
    @(negedge clock); checkOutput("bp_full_until_deq", a_ready, 0);
    @(posedge clock); #1;
    @(negedge clock); checkOutput("bp_reassert", a_ready, 1);
    @(posedge clock); #1; a_valid = 1'b0;
    drain();
    checkOutput("bp_count", seen.size(), 3);
    if (seen.size() >= 3) begin
      checkOutput("bp_order0", seen[0].source, 1);
      checkOutput("bp_order1", seen[1].source, 2);
      checkOutput("bp_order2", seen[2].source, 3);
    end

    $display("[TB] streaming throughput");
    d_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'd4, 3'd2, 4'(i), 12'h008, 4'h0, 32'h0, w, dv);
      checkOutput("stream_no_stall", w, 0);
      if (i > 0) checkOutput("stream_d_valid", dv, 1);
    end
    @(negedge clock); checkOutput("stream_last_resp", d_valid, 1);
    @(negedge clock); checkOutput("stream_empty", d_valid, 0);
    @(posedge clock); #1;

    $display("[TB] reset with queued responses");
    d_ready = 1'b0;
    applyStimulus(3'd4, 3'd2, 4'd9, 12'h008, 4'h0, 32'h0, w, dv);
    applyStimulus(3'd4, 3'd2, 4'd10, 12'h004, 4'h0, 32'h0, w, dv);
    pulseReset();
    @(negedge clock);
    checkOutput("rst_d_valid", d_valid, 0);
    checkOutput("rst_a_ready", a_ready, 1);
    @(posedge clock); #1;
    d_ready = 1'b1;
    seen.delete();
    applyStimulus(3'd4, 3'd2, 4'd7, 12'h008, 4'h0, 32'h0, w, dv);
    applyStimulus(3'd4, 3'd2, 4'd7, 12'h004, 4'h0, 32'h0, w, dv);
    drain();
    checkOutput("rst_count", seen.size(), 2);
    if (seen.size() >= 2) begin
      checkOutput("rst_store0", seen[0].data, 0);
      checkOutput("rst_store1", seen[1].data, 0);
    end

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 4)      a_opcode = 3'd4;
      else if (r < 6) a_opcode = 3'd0;
      else if (r < 8) a_opcode = 3'd1;
      else            a_opcode = 3'($urandom_range(2, 7));
      if (a_opcode == 3'd4 && r >= 8) a_opcode = 3'd5;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a_size = sz;
      idx = $urandom_range(0, WORDS + 1);
      off = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 3'd1) off[0] = 1'b0;
        else if (sz >= 3'd2) off = 2'b00;
      end
      a_address = ADDR_W'(idx * 4) | ADDR_W'(off);
      if ($urandom_range(0, 19) == 0) a_address = ADDR_W'($urandom);
      a_source = SOURCE_W'($urandom);
      a_mask   = 4'($urandom);
      a_data   = $urandom;
      d_ready  = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 149) == 0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    a_valid = 1'b0;
    d_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
